// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and enums for the register write-port arbiter.
// Register and requester indices match the bit positions on the packed request buses.
package reg_write_arbiter_pkg;

    localparam int WORD_SIZE = 19;
    localparam int NUM_REQ   = 3;
    localparam int NUM_REGS  = 3;

    typedef enum logic [1:0] {
        REG_A    = 2'd0,
        REG_B    = 2'd1,
        REG_C    = 2'd2,
        REG_NONE = 2'd3
    } reg_idx_e;

    typedef enum logic [1:0] {
        RQ_ALU = 2'd0,
        RQ_MEM = 2'd1,
        RQ_IMM = 2'd2
    } req_idx_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins, zero latency.
// en=0 suppresses every grant; the pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx = PW'((int'(ptr) + i) % N);
                if (!gnt_vld && req[idx]) begin
                    gnt_vld      = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = idx;
                end
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the A/B/C register write port; grant and load strobe one cycle after request.
// STALL blocks new grants only; a write already latched always issues in the following cycle.
module reg_write_arbiter #(
    parameter int WORD_SIZE = reg_write_arbiter_pkg::WORD_SIZE,
    parameter int NUM_REQ   = reg_write_arbiter_pkg::NUM_REQ,
    parameter int NUM_REGS  = reg_write_arbiter_pkg::NUM_REGS
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [2*NUM_REQ-1:0]          REQ_DEST,
    input  logic [WORD_SIZE*NUM_REQ-1:0]  REQ_DATA,
    input  logic                          STALL,
    input  logic                          ERR_CLR,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REGS-1:0]           LOAD_REG,
    output logic [WORD_SIZE-1:0]          WR_DATA,
    output logic                          BUSY,
    output logic                          ERR
);

    import reg_write_arbiter_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                 state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          ptr_nxt;
    logic [NUM_REQ-1:0]     req_eff;
    logic [NUM_REQ-1:0]     win;
    logic [PW-1:0]          win_idx;
    logic                   grant;
    logic [1:0]             win_dest;
    logic [WORD_SIZE-1:0]   win_data;
    logic [NUM_REGS-1:0]    load_nxt;
    logic                   win_err;

    // A requester still seeing its GNT is presenting stale state, so it sits out this round.
    assign req_eff = REQ & ~GNT;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req     (req_eff),
        .ptr     (ptr),
        .en      (~STALL),
        .gnt     (win),
        .gnt_idx (win_idx),
        .gnt_vld (grant)
    );

    always_comb begin
        win_dest = REQ_DEST[2*int'(win_idx) +: 2];
        win_data = REQ_DATA[WORD_SIZE*int'(win_idx) +: WORD_SIZE];
        load_nxt = '0;
        if (int'(win_dest) < NUM_REGS) begin
            load_nxt[win_dest] = 1'b1;
        end
        win_err  = grant && (win_dest == REG_NONE);
        ptr_nxt  = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end

    assign BUSY = (state == ISSUE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ptr      <= '0;
            GNT      <= '0;
            LOAD_REG <= '0;
            WR_DATA  <= '0;
            ERR      <= 1'b0;
        end else begin
            GNT <= win;
            // A new invalid-destination grant outranks a simultaneous clear.
            ERR <= win_err | (ERR & ~ERR_CLR);
            if (grant) begin
                ptr     <= ptr_nxt;
                WR_DATA <= win_data;
            end
            LOAD_REG <= grant ? load_nxt : '0;
            case (state)
                IDLE:    state <= grant ? ISSUE : IDLE;
                ISSUE:   state <= grant ? ISSUE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, multi-cycle corner sequences, then
// randomized traffic checked against a behavioural round-robin model.
module tb_reg_write_arbiter;

    localparam int W = 19;
    localparam logic [W-1:0] D0 = 19'h1ABCD;
    localparam logic [W-1:0] D1 = 19'h02222;
    localparam logic [W-1:0] D2 = 19'h73333;

    logic          CLK;
    logic          RST_N;
    logic [2:0]    REQ;
    logic [5:0]    REQ_DEST;
    logic [3*W-1:0] REQ_DATA;
    logic          STALL;
    logic          ERR_CLR;
    logic [2:0]    GNT;
    logic [2:0]    LOAD_REG;
    logic [W-1:0]  WR_DATA;
    logic          BUSY;
    logic          ERR;

    int vectors = 0;
    int fails   = 0;

    reg_write_arbiter dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .REQ      (REQ),
        .REQ_DEST (REQ_DEST),
        .REQ_DATA (REQ_DATA),
        .STALL    (STALL),
        .ERR_CLR  (ERR_CLR),
        .GNT      (GNT),
        .LOAD_REG (LOAD_REG),
        .WR_DATA  (WR_DATA),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]   req;
        logic [5:0]   dst;
        logic         stall;
        logic         clr;
        logic [2:0]   gnt;
        logic [2:0]   load;
        logic [W-1:0] wr;
        logic         busy;
        logic         err;
    } vec_t;

    vec_t tbl[22];

    // Behavioural model state: what the outputs must show in the next cycle.
    int           m_ptr;
    logic [2:0]   m_gnt;
    logic [2:0]   m_load;
    logic [W-1:0] m_wr;
    logic         m_busy;
    logic         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] gnt, input logic [2:0] load,
                           input logic [W-1:0] wr, input logic busy, input logic err);
        chk({tag, ".GNT"},      32'(GNT),      32'(gnt));
        chk({tag, ".LOAD_REG"}, 32'(LOAD_REG), 32'(load));
        chk({tag, ".WR_DATA"},  32'(WR_DATA),  32'(wr));
        chk({tag, ".BUSY"},     32'(BUSY),     32'(busy));
        chk({tag, ".ERR"},      32'(ERR),      32'(err));
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_gnt  = '0;
        m_load = '0;
        m_wr   = '0;
        m_busy = 1'b0;
        m_err  = 1'b0;
    endtask

    // Applies the arbitration rules to the inputs currently driven.
    task automatic model_step();
        int w;
        int d;
        logic new_err;
        w = -1;
        new_err = 1'b0;
        if (!STALL) begin
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (m_ptr + k) % 3;
                if (w < 0 && REQ[c] && !m_gnt[c]) w = c;
            end
        end
        if (w >= 0) begin
            d       = int'(REQ_DEST[2*w +: 2]);
            m_gnt   = 3'b001 << w;
            m_wr    = REQ_DATA[W*w +: W];
            m_load  = (d < 3) ? (3'b001 << d) : 3'b000;
            new_err = (d == 3);
            m_busy  = 1'b1;
            m_ptr   = (w + 1) % 3;
        end else begin
            m_gnt  = '0;
            m_load = '0;
            m_busy = 1'b0;
        end
        m_err = new_err | (m_err & ~ERR_CLR);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N   = 1'b0;
        REQ     = '0;
        STALL   = 1'b0;
        ERR_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N    = 1'b0;
        REQ      = '0;
        REQ_DEST = '0;
        REQ_DATA = {D2, D1, D0};
        STALL    = 1'b0;
        ERR_CLR  = 1'b0;

        // {req, dst={d2,d1,d0}, stall, clr} -> outputs seen in the following cycle
        tbl[0]  = '{3'b111, 6'b10_01_00, 1'b0, 1'b0, 3'b001, 3'b001, D0, 1'b1, 1'b0};
        tbl[1]  = '{3'b111, 6'b10_01_00, 1'b0, 1'b0, 3'b010, 3'b010, D1, 1'b1, 1'b0};
        tbl[2]  = '{3'b111, 6'b10_01_00, 1'b0, 1'b0, 3'b100, 3'b100, D2, 1'b1, 1'b0};
        tbl[3]  = '{3'b111, 6'b10_01_00, 1'b0, 1'b0, 3'b001, 3'b001, D0, 1'b1, 1'b0};
        tbl[4]  = '{3'b000, 6'b10_01_00, 1'b0, 1'b0, 3'b000, 3'b000, D0, 1'b0, 1'b0};
        tbl[5]  = '{3'b001, 6'b00_00_01, 1'b0, 1'b0, 3'b001, 3'b010, D0, 1'b1, 1'b0};
        tbl[6]  = '{3'b000, 6'b00_00_01, 1'b0, 1'b0, 3'b000, 3'b000, D0, 1'b0, 1'b0};
        tbl[7]  = '{3'b010, 6'b00_01_00, 1'b1, 1'b0, 3'b000, 3'b000, D0, 1'b0, 1'b0};
        tbl[8]  = '{3'b010, 6'b00_01_00, 1'b1, 1'b0, 3'b000, 3'b000, D0, 1'b0, 1'b0};
        tbl[9]  = '{3'b010, 6'b00_01_00, 1'b1, 1'b0, 3'b000, 3'b000, D0, 1'b0, 1'b0};
        tbl[10] = '{3'b010, 6'b00_01_00, 1'b1, 1'b0, 3'b000, 3'b000, D0, 1'b0, 1'b0};
        tbl[11] = '{3'b010, 6'b00_01_00, 1'b0, 1'b0, 3'b010, 3'b010, D1, 1'b1, 1'b0};
        tbl[12] = '{3'b000, 6'b00_01_00, 1'b0, 1'b0, 3'b000, 3'b000, D1, 1'b0, 1'b0};
        tbl[13] = '{3'b100, 6'b11_00_00, 1'b0, 1'b0, 3'b100, 3'b000, D2, 1'b1, 1'b1};
        tbl[14] = '{3'b000, 6'b11_00_00, 1'b0, 1'b0, 3'b000, 3'b000, D2, 1'b0, 1'b1};
        tbl[15] = '{3'b000, 6'b11_00_00, 1'b0, 1'b1, 3'b000, 3'b000, D2, 1'b0, 1'b0};
        tbl[16] = '{3'b100, 6'b11_00_00, 1'b0, 1'b1, 3'b100, 3'b000, D2, 1'b1, 1'b1};
        tbl[17] = '{3'b000, 6'b11_00_00, 1'b0, 1'b0, 3'b000, 3'b000, D2, 1'b0, 1'b1};
        tbl[18] = '{3'b010, 6'b00_10_00, 1'b0, 1'b0, 3'b010, 3'b100, D1, 1'b1, 1'b1};
        tbl[19] = '{3'b010, 6'b00_10_00, 1'b0, 1'b0, 3'b000, 3'b000, D1, 1'b0, 1'b1};
        tbl[20] = '{3'b010, 6'b00_10_00, 1'b0, 1'b0, 3'b010, 3'b100, D1, 1'b1, 1'b1};
        tbl[21] = '{3'b000, 6'b00_10_00, 1'b0, 1'b1, 3'b000, 3'b000, D1, 1'b0, 1'b0};

        repeat (2) @(negedge CLK);
        chk_out("reset", 3'b000, 3'b000, '0, 1'b0, 1'b0);
        RST_N = 1'b1;

        for (int i = 0; i < 22; i++) begin
            REQ      = tbl[i].req;
            REQ_DEST = tbl[i].dst;
            STALL    = tbl[i].stall;
            ERR_CLR  = tbl[i].clr;
            @(negedge CLK);
            chk_out($sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].load, tbl[i].wr,
                    tbl[i].busy, tbl[i].err);
        end

        // STALL raised right after the grant edge must not cancel the issuing write.
        REQ      = 3'b100;
        REQ_DEST = 6'b00_00_00;
        STALL    = 1'b0;
        ERR_CLR  = 1'b0;
        @(posedge CLK);
        #1;
        STALL = 1'b1;
        REQ   = 3'b000;
        @(negedge CLK);
        chk_out("stall_in_issue", 3'b100, 3'b001, D2, 1'b1, 1'b0);
        @(negedge CLK);
        chk_out("stall_after_issue", 3'b000, 3'b000, D2, 1'b0, 1'b0);
        STALL = 1'b0;

        // Asynchronous reset while LOAD_REG is active.
        REQ      = 3'b010;
        REQ_DEST = 6'b00_01_00;
        @(posedge CLK);
        #1;
        REQ = 3'b000;
        chk("mid_issue.LOAD_REG", 32'(LOAD_REG), 32'(3'b010));
        #2;
        RST_N = 1'b0;
        #1;
        chk_out("async_reset", 3'b000, 3'b000, '0, 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk_out("post_reset_idle", 3'b000, 3'b000, '0, 1'b0, 1'b0);
        end
        REQ      = 3'b111;
        REQ_DEST = 6'b10_01_00;
        @(negedge CLK);
        chk("post_reset_ptr.GNT", 32'(GNT), 32'(3'b001));
        REQ = 3'b000;

        // Randomized traffic against the behavioural model.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            REQ = 3'($urandom_range(0, 7));
            for (int r = 0; r < 3; r++) begin
                REQ_DEST[2*r +: 2] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                REQ_DATA[W*r +: W] = W'($urandom);
            end
            STALL   = ($urandom_range(0, 4) == 0);
            ERR_CLR = ($urandom_range(0, 9) == 0);
            model_step();
            @(negedge CLK);
            chk_out($sformatf("rand[%0d]", n), m_gnt, m_load, m_wr, m_busy, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
